// File: rtl/clk_en_pkg.sv
// Shared types and sizing helpers for the fractional clock-enable generator.
package clk_en_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK,
    COUNT,
    RUN
  } state_e;

  function automatic int unsigned ch_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_en_channel.sv
// One DDS channel: phase accumulator with carry strobe and a staged increment
// that is swapped in only on a carry so the output period never glitches.
module clk_en_channel #(
  parameter int unsigned      ACC_W   = 32,
  parameter logic [ACC_W-1:0] INC_RST = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             run_i,
  input  logic             sync_i,
  input  logic             we_i,
  input  logic [ACC_W-1:0] wdata_i,
  output logic             ce_o,
  output logic             phase_o,
  output logic             pend_o
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] inc_q, inc_d;
  logic [ACC_W-1:0] stage_q, stage_d;
  logic             pend_q, pend_d;
  logic             ce_q, ce_d;
  logic [ACC_W:0]   sum;
  logic             carry;
  logic             load;

  always_comb begin
    sum     = {1'b0, acc_q} + {1'b0, inc_q};
    carry   = run_i & ~sync_i & sum[ACC_W];
    load    = pend_q & (sync_i | carry | (inc_q == '0) | ~run_i);
    inc_d   = inc_q;
    stage_d = stage_q;
    pend_d  = pend_q;
    // A write coinciding with sync bypasses the stage so the cleared phase
    // starts with the new increment; otherwise the old stage loads first.
    if (sync_i && we_i) begin
      inc_d  = wdata_i;
      pend_d = 1'b0;
    end else begin
      if (load) begin
        inc_d  = stage_q;
        pend_d = 1'b0;
      end
      if (we_i) begin
        stage_d = wdata_i;
        pend_d  = 1'b1;
      end
    end
    if (!run_i || sync_i) begin
      acc_d = '0;
      ce_d  = 1'b0;
    end else begin
      acc_d = sum[ACC_W-1:0];
      ce_d  = carry;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q   <= '0;
      inc_q   <= INC_RST;
      stage_q <= '0;
      pend_q  <= 1'b0;
      ce_q    <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      inc_q   <= inc_d;
      stage_q <= stage_d;
      pend_q  <= pend_d;
      ce_q    <= ce_d;
    end
  end

  assign ce_o    = ce_q;
  assign phase_o = acc_q[ACC_W-1];
  assign pend_o  = pend_q;

endmodule

// File: rtl/clk_en_gen.sv
// N-channel fractional clock-enable generator gated on a qualified PLL lock,
// with a synchronised active-low downstream reset.
module clk_en_gen
  import clk_en_pkg::*;
#(
  parameter int unsigned                CHANNELS    = 4,
  parameter int unsigned                ACC_W       = 32,
  parameter int unsigned                LOCK_CYCLES = 1024,
  parameter logic [CHANNELS*ACC_W-1:0]  INC_INIT    = {CHANNELS{32'h2000_0000}},
  localparam int unsigned               CH_W        = ch_w(CHANNELS)
) (
  input  logic                clkin,
  input  logic                rst,
  input  logic                pll_locked,
  input  logic                sync,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [ACC_W-1:0]    cfg_inc,
  output logic [CHANNELS-1:0] cfg_pend,
  output logic [CHANNELS-1:0] ce,
  output logic [CHANNELS-1:0] phase,
  output logic                ready,
  output logic                rst_out
);

  localparam int unsigned     CNT_W    = cnt_w(LOCK_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lk_s1_q, lk_s2_q;
  logic             ready_q, ready_d;
  logic             lk;

  assign lk = lk_s2_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      WAIT_LOCK: begin
        if (lk) begin
          state_d = COUNT;
          cnt_d   = CNT_W'(1);
        end
      end
      COUNT: begin
        if (!lk) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        if (!lk) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
    // Channels follow the next state so their outputs switch together with ready.
    ready_d = (state_d == RUN);
  end

  always_ff @(posedge clkin or negedge rst) begin
    if (!rst) begin
      lk_s1_q <= 1'b0;
      lk_s2_q <= 1'b0;
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      lk_s1_q <= pll_locked;
      lk_s2_q <= lk_s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  assign ready   = ready_q;
  assign rst_out = ready_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    clk_en_channel #(
      .ACC_W   (ACC_W),
      .INC_RST (INC_INIT[i*ACC_W +: ACC_W])
    ) u_ch (
      .clk_i   (clkin),
      .rst_ni  (rst),
      .run_i   (ready_d),
      .sync_i  (sync),
      .we_i    (cfg_we && (cfg_ch == CH_W'(i))),
      .wdata_i (cfg_inc),
      .ce_o    (ce[i]),
      .phase_o (phase[i]),
      .pend_o  (cfg_pend[i])
    );
  end

endmodule

// File: tb/tb_clk_en_gen.sv
// Directed and randomized checks of clk_en_gen against a cycle-level
// arithmetic reference model (lock streak counter plus modular phase sums).
module tb_clk_en_gen;

  localparam int unsigned CH = 3;
  localparam int unsigned AW = 32;
  localparam int unsigned LC = 16;
  localparam logic [CH*AW-1:0] INIT = {32'h5555_5555, 32'h8000_0000, 32'h2000_0000};

  logic          clkin = 1'b0;
  logic          rst = 1'b0;
  logic          pll_locked = 1'b0;
  logic          sync = 1'b0;
  logic          cfg_we = 1'b0;
  logic [1:0]    cfg_ch = '0;
  logic [AW-1:0] cfg_inc = '0;
  logic [CH-1:0] cfg_pend, ce, phase;
  logic          ready, rst_out;

  int ncmp = 0;
  int nfail = 0;

  // reference model state
  bit              d1, d2;
  int              streak;
  bit              m_run;
  longint unsigned m_acc[CH], m_inc[CH], m_stage[CH];
  bit              m_pend[CH], m_ce[CH];

  clk_en_gen #(
    .CHANNELS    (CH),
    .ACC_W       (AW),
    .LOCK_CYCLES (LC),
    .INC_INIT    (INIT)
  ) dut (
    .clkin      (clkin),
    .rst        (rst),
    .pll_locked (pll_locked),
    .sync       (sync),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_inc    (cfg_inc),
    .cfg_pend   (cfg_pend),
    .ce         (ce),
    .phase      (phase),
    .ready      (ready),
    .rst_out    (rst_out)
  );

  always #5 clkin = ~clkin;

  task automatic model_reset();
    logic [CH*AW-1:0] init_v;
    init_v = INIT;
    d1 = 0; d2 = 0; streak = 0; m_run = 0;
    for (int i = 0; i < CH; i++) begin
      m_acc[i] = 0; m_stage[i] = 0; m_pend[i] = 0; m_ce[i] = 0;
      m_inc[i] = longint'(init_v[i*AW +: AW]);
    end
  endtask

  task automatic model_edge();
    bit lk, wr, carry;
    longint unsigned s;
    lk = d2; d2 = d1; d1 = pll_locked;
    streak = lk ? ((streak < int'(LC)) ? streak + 1 : streak) : 0;
    m_run = (streak >= int'(LC));
    for (int i = 0; i < CH; i++) begin
      wr    = cfg_we && (int'(cfg_ch) == i);
      s     = m_acc[i] + m_inc[i];
      carry = m_run && !sync && (s >= 64'h1_0000_0000);
      if (sync && wr) begin
        m_inc[i] = longint'(cfg_inc); m_pend[i] = 0;
      end else begin
        if (m_pend[i] && (sync || carry || m_inc[i] == 0 || !m_run)) begin
          m_inc[i] = m_stage[i]; m_pend[i] = 0;
        end
        if (wr) begin
          m_stage[i] = longint'(cfg_inc); m_pend[i] = 1;
        end
      end
      if (!m_run || sync) begin
        m_acc[i] = 0; m_ce[i] = 0;
      end else begin
        m_acc[i] = s % 64'h1_0000_0000; m_ce[i] = carry;
      end
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    logic [CH-1:0] e_ce, e_ph, e_pd;
    for (int i = 0; i < CH; i++) begin
      e_ce[i] = m_ce[i];
      e_ph[i] = m_acc[i][AW-1];
      e_pd[i] = m_pend[i];
    end
    check("ready", 64'(ready), 64'(m_run));
    check("rst_out", 64'(rst_out), 64'(m_run));
    check("ce", 64'(ce), 64'(e_ce));
    check("phase", 64'(phase), 64'(e_ph));
    check("cfg_pend", 64'(cfg_pend), 64'(e_pd));
  endtask

  task automatic step();
    @(posedge clkin);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 60) begin
      step();
      n++;
    end
  endtask

  // Cycle index of each channel's first ce; cycle 1 is the current sample if now_is_one.
  task automatic first_ce(input string tag, input int e0, input int e1, input int e2,
                          input bit now_is_one);
    int first[CH];
    int cyc;
    for (int i = 0; i < CH; i++) first[i] = 0;
    cyc = now_is_one ? 1 : 0;
    if (now_is_one)
      for (int i = 0; i < CH; i++) if (ce[i]) first[i] = 1;
    while (cyc < 12) begin
      step();
      cyc++;
      for (int i = 0; i < CH; i++) if (ce[i] && first[i] == 0) first[i] = cyc;
    end
    check({tag, "_ch0"}, 64'(first[0]), 64'(e0));
    check({tag, "_ch1"}, 64'(first[1]), 64'(e1));
    check({tag, "_ch2"}, 64'(first[2]), 64'(e2));
  endtask

  task automatic steps_to_ce0(output int k);
    k = 0;
    do begin
      step();
      k++;
    end while (!ce[0] && k < 20);
  endtask

  initial begin
    int n, k;
    model_reset();
    #12;
    compare_all();
    rst = 1'b1;
    pll_locked = 1'b1;

    // lock qualification with a one-cycle dropout at cycle 10
    for (int c = 0; c < 9; c++) step();
    pll_locked = 1'b0;
    step();
    pll_locked = 1'b1;
    wait_ready(n);
    check("relock_latency", 64'(n), 64'(18));

    // first strobe after entering RUN: ceil(2^32/inc)
    first_ce("first_ce", 8, 2, 4, 1'b1);

    // glitch-free retune of channel 0 mid-period
    steps_to_ce0(k);
    step();
    step();
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_inc = 32'h4000_0000;
    step();
    cfg_we = 1'b0;
    check("retune_pend", 64'(cfg_pend[0]), 64'(1));
    steps_to_ce0(k);
    check("retune_wait", 64'(k), 64'(5));
    check("retune_pend_clr", 64'(cfg_pend[0]), 64'(0));
    steps_to_ce0(k);
    check("retune_gap", 64'(k), 64'(4));

    // sync together with a write on channel 1
    sync = 1'b1; cfg_we = 1'b1; cfg_ch = 2'd1; cfg_inc = 32'h4000_0000;
    step();
    sync = 1'b0; cfg_we = 1'b0;
    check("sync_pend", 64'(cfg_pend), 64'(0));
    first_ce("sync_ce", 4, 4, 4, 1'b0);

    // write to a channel index beyond CHANNELS
    cfg_we = 1'b1; cfg_ch = 2'd3; cfg_inc = 32'h1234_5678;
    step();
    cfg_we = 1'b0;
    check("bad_ch_pend", 64'(cfg_pend), 64'(0));

    // lock loss and relock with retained increments
    pll_locked = 1'b0;
    step(); step(); step();
    check("lockloss_ready", 64'(ready), 64'(0));
    check("lockloss_ce", 64'(ce), 64'(0));
    pll_locked = 1'b1;
    wait_ready(n);
    check("lockloss_relock", 64'(n), 64'(18));
    first_ce("relock_ce", 4, 4, 4, 1'b1);

    // randomized traffic
    for (int c = 0; c < 2000; c++) begin
      cfg_we = ($urandom_range(0, 7) == 0);
      cfg_ch = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0: cfg_inc = 32'h0;
        1: cfg_inc = 32'h8000_0000;
        2: cfg_inc = 32'h2000_0000;
        3: cfg_inc = 32'h5555_5555;
        4: cfg_inc = 32'h4000_0000;
        default: cfg_inc = $urandom;
      endcase
      sync = ($urandom_range(0, 39) == 0);
      pll_locked = ($urandom_range(0, 299) != 0);
      step();
    end
    cfg_we = 1'b0; sync = 1'b0; pll_locked = 1'b1;
    wait_ready(n);
    check("random_relock", 64'(ready), 64'(1));

    // asynchronous reset between clock edges
    step();
    #2 rst = 1'b0;
    #1;
    model_reset();
    compare_all();
    #2 rst = 1'b1;
    wait_ready(n);
    check("reset_relock", 64'(n), 64'(18));
    first_ce("reset_ce", 8, 2, 4, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
